sudoku_board_engine: RTL and testbench

//  Parametrised board-state engine sitting between the keypad/cursor front end and display_controller.
//  It holds the N x N grid and the given-cell mask, and loads a puzzle over a ready/valid stream.
//  It performs cursor moves with wrap-around and locked-cell edits.
//  It runs a sequential row/column/box validation scan that reports board_ok/board_full.
//  It generalises the fixed 9x9 game logic to any BOX_DIM: 2 gives 4x4, 3 gives 9x9, 4 gives 16x16.

---
 rtl/sudoku_pkg.sv | 20 ++
 rtl/sudoku_board_engine_if.sv | 47 ++++
 rtl/sudoku_unit_addr.sv | 37 +++
 rtl/sudoku_board_engine.sv | 201 ++++++++++++++++++++
 tb/tb_sudoku_board_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and size helpers for the sudoku board engine and its address map.
package sudoku_pkg;

  localparam int unsigned BOX_DIM_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    VALIDATE = 2'd2
  } engine_state_t;

  function automatic int unsigned n_of(input int unsigned box_dim);
    return box_dim * box_dim;
  endfunction

  function automatic int unsigned val_w(input int unsigned box_dim);
    return $clog2(box_dim * box_dim + 1);
  endfunction

endpackage

// File: rtl/sudoku_board_engine_if.sv
// Front-end facing bundle: puzzle load stream, edit/move strobes, scan control and board view.
interface sudoku_board_engine_if #(
  parameter int unsigned BOX_DIM = sudoku_pkg::BOX_DIM_DEFAULT
);
  import sudoku_pkg::*;

  localparam int unsigned N     = n_of(BOX_DIM);
  localparam int unsigned VAL_W = val_w(BOX_DIM);
  localparam int unsigned POS_W = $clog2(N);

  logic                              load_start;
  logic                              load_valid;
  logic [VAL_W-1:0]                  load_value;
  logic                              load_ready;
  logic                              load_done;
  logic                              move_up;
  logic                              move_down;
  logic                              move_left;
  logic                              move_right;
  logic                              write_en;
  logic [VAL_W-1:0]                  user_value;
  logic                              edit_reject;
  logic                              validate_start;
  logic                              valid_done;
  logic                              board_ok;
  logic                              board_full;
  logic                              busy;
  logic [POS_W-1:0]                  cursor_row;
  logic [POS_W-1:0]                  cursor_col;
  logic [N-1:0][N-1:0][VAL_W-1:0]    display_grid;
  logic [N-1:0][N-1:0]               given_mask;

  modport master (
    output load_start, load_valid, load_value, move_up, move_down, move_left, move_right,
           write_en, user_value, validate_start,
    input  load_ready, load_done, edit_reject, valid_done, board_ok, board_full, busy,
           cursor_row, cursor_col, display_grid, given_mask
  );

  modport slave (
    input  load_start, load_valid, load_value, move_up, move_down, move_left, move_right,
           write_en, user_value, validate_start,
    output load_ready, load_done, edit_reject, valid_done, board_ok, board_full, busy,
           cursor_row, cursor_col, display_grid, given_mask
  );

endinterface

// File: rtl/sudoku_unit_addr.sv
// Maps scan position (unit, element) to a grid cell: units are rows, then columns, then boxes.
module sudoku_unit_addr
  import sudoku_pkg::*;
#(
  parameter  int unsigned BOX_DIM = BOX_DIM_DEFAULT,
  localparam int unsigned N       = n_of(BOX_DIM),
  localparam int unsigned POS_W   = $clog2(N),
  localparam int unsigned UNIT_W  = $clog2(3 * N)
) (
  input  logic [UNIT_W-1:0] unit_idx,
  input  logic [POS_W-1:0]  elem_idx,
  output logic [POS_W-1:0]  row,
  output logic [POS_W-1:0]  col
);

  int unsigned u;
  int unsigned k;
  int unsigned b;

  always_comb begin
    u   = 32'(unit_idx);
    k   = 32'(elem_idx);
    b   = 0;
    row = elem_idx;
    col = elem_idx;
    if (u < N) begin
      row = POS_W'(u);
    end else if (u < 2 * N) begin
      col = POS_W'(u - N);
    end else begin
      b   = u - 2 * N;
      row = POS_W'((b / BOX_DIM) * BOX_DIM + k / BOX_DIM);
      col = POS_W'((b % BOX_DIM) * BOX_DIM + k % BOX_DIM);
    end
  end

endmodule

// File: rtl/sudoku_board_engine.sv
// Board-state engine: grid/given storage, streamed puzzle load, cursor edits and a
// one-cell-per-cycle duplicate/emptiness scan over all rows, columns and boxes.
module sudoku_board_engine
  import sudoku_pkg::*;
#(
  parameter int unsigned BOX_DIM = BOX_DIM_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  sudoku_board_engine_if.slave  bus
);

  localparam int unsigned N      = n_of(BOX_DIM);
  localparam int unsigned VAL_W  = val_w(BOX_DIM);
  localparam int unsigned POS_W  = $clog2(N);
  localparam int unsigned IDX_W  = $clog2(N * N);
  localparam int unsigned UNIT_W = $clog2(3 * N);

  engine_state_t                  state_q, state_d;
  logic [N-1:0][N-1:0][VAL_W-1:0] grid_q, grid_d;
  logic [N-1:0][N-1:0]            mask_q, mask_d;
  logic [POS_W-1:0]               row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [UNIT_W-1:0]              unit_q, unit_d;
  logic [POS_W-1:0]               elem_q, elem_d;
  logic [N-1:0]                   seen_q, seen_d;
  logic                           ok_acc_q, ok_acc_d, full_acc_q, full_acc_d;
  logic                           board_ok_q, board_ok_d, board_full_q, board_full_d;
  logic                           load_done_q, load_done_d;
  logic                           edit_reject_q, edit_reject_d;
  logic                           valid_done_q, valid_done_d;

  logic [POS_W-1:0] scan_row, scan_col, load_row, load_col;
  logic [VAL_W-1:0] scan_val, load_val;
  logic [N-1:0]     seen_base, digit_bit;
  logic             ok_n, full_n;

  sudoku_unit_addr #(.BOX_DIM(BOX_DIM)) u_unit_addr (
    .unit_idx (unit_q),
    .elem_idx (elem_q),
    .row      (scan_row),
    .col      (scan_col)
  );

  // Scan datapath: seen mask restarts at the first element of every unit.
  assign scan_val  = grid_q[scan_row][scan_col];
  assign seen_base = (elem_q == '0) ? '0 : seen_q;
  assign digit_bit = (scan_val == '0) ? '0 : (N'(1) << (scan_val - VAL_W'(1)));
  assign ok_n      = ok_acc_q & ~|(seen_base & digit_bit);
  assign full_n    = full_acc_q & (scan_val != '0);

  // Out-of-range load values are stored as empty, non-given cells.
  assign load_row = POS_W'(32'(idx_q) / N);
  assign load_col = POS_W'(32'(idx_q) % N);
  assign load_val = (bus.load_value > VAL_W'(N)) ? '0 : bus.load_value;

  always_comb begin
    state_d       = state_q;
    grid_d        = grid_q;
    mask_d        = mask_q;
    row_d         = row_q;
    col_d         = col_q;
    idx_d         = idx_q;
    unit_d        = unit_q;
    elem_d        = elem_q;
    seen_d        = seen_q;
    ok_acc_d      = ok_acc_q;
    full_acc_d    = full_acc_q;
    board_ok_d    = board_ok_q;
    board_full_d  = board_full_q;
    load_done_d   = 1'b0;
    edit_reject_d = 1'b0;
    valid_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d      = LOAD;
          grid_d       = '0;
          mask_d       = '0;
          board_ok_d   = 1'b0;
          board_full_d = 1'b0;
          idx_d        = '0;
        end else if (bus.validate_start) begin
          state_d    = VALIDATE;
          unit_d     = '0;
          elem_d     = '0;
          seen_d     = '0;
          ok_acc_d   = 1'b1;
          full_acc_d = 1'b1;
        end else begin
          // Write targets the pre-move cursor; moves land on the same edge.
          if (bus.write_en) begin
            if (mask_q[row_q][col_q] || (bus.user_value > VAL_W'(N))) begin
              edit_reject_d = 1'b1;
            end else begin
              grid_d[row_q][col_q] = bus.user_value;
            end
          end
          if (bus.move_up && !bus.move_down) begin
            row_d = (row_q == '0) ? POS_W'(N - 1) : row_q - POS_W'(1);
          end else if (bus.move_down && !bus.move_up) begin
            row_d = (row_q == POS_W'(N - 1)) ? '0 : row_q + POS_W'(1);
          end
          if (bus.move_left && !bus.move_right) begin
            col_d = (col_q == '0) ? POS_W'(N - 1) : col_q - POS_W'(1);
          end else if (bus.move_right && !bus.move_left) begin
            col_d = (col_q == POS_W'(N - 1)) ? '0 : col_q + POS_W'(1);
          end
        end
      end

      LOAD: begin
        if (bus.load_valid) begin
          grid_d[load_row][load_col] = load_val;
          mask_d[load_row][load_col] = (load_val != '0);
          if (idx_q == IDX_W'(N * N - 1)) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
            row_d       = '0;
            col_d       = '0;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      VALIDATE: begin
        seen_d     = seen_base | digit_bit;
        ok_acc_d   = ok_n;
        full_acc_d = full_n;
        if (elem_q == POS_W'(N - 1)) begin
          elem_d = '0;
          unit_d = unit_q + UNIT_W'(1);
          if (unit_q == UNIT_W'(3 * N - 1)) begin
            state_d      = IDLE;
            board_ok_d   = ok_n;
            board_full_d = full_n;
            valid_done_d = 1'b1;
          end
        end else begin
          elem_d = elem_q + POS_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grid_q        <= '0;
      mask_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      idx_q         <= '0;
      unit_q        <= '0;
      elem_q        <= '0;
      seen_q        <= '0;
      ok_acc_q      <= 1'b0;
      full_acc_q    <= 1'b0;
      board_ok_q    <= 1'b0;
      board_full_q  <= 1'b0;
      load_done_q   <= 1'b0;
      edit_reject_q <= 1'b0;
      valid_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grid_q        <= grid_d;
      mask_q        <= mask_d;
      row_q         <= row_d;
      col_q         <= col_d;
      idx_q         <= idx_d;
      unit_q        <= unit_d;
      elem_q        <= elem_d;
      seen_q        <= seen_d;
      ok_acc_q      <= ok_acc_d;
      full_acc_q    <= full_acc_d;
      board_ok_q    <= board_ok_d;
      board_full_q  <= board_full_d;
      load_done_q   <= load_done_d;
      edit_reject_q <= edit_reject_d;
      valid_done_q  <= valid_done_d;
    end
  end

  assign bus.load_ready   = (state_q == LOAD);
  assign bus.busy         = (state_q != IDLE);
  assign bus.load_done    = load_done_q;
  assign bus.edit_reject  = edit_reject_q;
  assign bus.valid_done   = valid_done_q;
  assign bus.board_ok     = board_ok_q;
  assign bus.board_full   = board_full_q;
  assign bus.cursor_row   = row_q;
  assign bus.cursor_col   = col_q;
  assign bus.display_grid = grid_q;
  assign bus.given_mask   = mask_q;

endmodule

// File: tb/tb_sudoku_board_engine.sv
// Directed bench for the sudoku board engine: 9x9 and 4x4 instances sharing one clock/reset.
module tb_sudoku_board_engine;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sudoku_board_engine_if #(.BOX_DIM(3)) bus3 ();
  sudoku_board_engine_if #(.BOX_DIM(2)) bus2 ();

  sudoku_board_engine #(.BOX_DIM(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3.slave));
  sudoku_board_engine #(.BOX_DIM(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0] sol3 [9][9];
  logic [3:0] exp3 [9][9];
  logic       expm3 [9][9];
  logic [3:0] puz3 [81];
  logic [2:0] sol2 [4][4];
  logic [2:0] exp2 [4][4];
  logic       expm2 [4][4];
  logic [2:0] puz2 [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Known-valid Latin-box pattern: row shift = box*r + r/box.
  function automatic int sol_val(input int box, input int r, input int c);
    return ((r * box + r / box + c) % (box * box)) + 1;
  endfunction

  function automatic int grid3_mism();
    int m = 0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        if (bus3.display_grid[r][c] !== exp3[r][c] || bus3.given_mask[r][c] !== expm3[r][c]) m++;
    return m;
  endfunction

  function automatic int grid2_mism();
    int m = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (bus2.display_grid[r][c] !== exp2[r][c] || bus2.given_mask[r][c] !== expm2[r][c]) m++;
    return m;
  endfunction

  task automatic drive3(input logic up, dn, lf, rt, we, input logic [3:0] val);
    bus3.move_up = up; bus3.move_down = dn; bus3.move_left = lf; bus3.move_right = rt;
    bus3.write_en = we; bus3.user_value = val;
    tick();
    bus3.move_up = 0; bus3.move_down = 0; bus3.move_left = 0; bus3.move_right = 0;
    bus3.write_en = 0; bus3.user_value = 0;
  endtask

  task automatic drive2(input logic up, dn, lf, rt, we, input logic [2:0] val);
    bus2.move_up = up; bus2.move_down = dn; bus2.move_left = lf; bus2.move_right = rt;
    bus2.write_en = we; bus2.user_value = val;
    tick();
    bus2.move_up = 0; bus2.move_down = 0; bus2.move_left = 0; bus2.move_right = 0;
    bus2.write_en = 0; bus2.user_value = 0;
  endtask

  task automatic move_to3(input int r, input int c);
    for (int i = 0; i < 10 && bus3.cursor_row != 4'(r); i++) drive3(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10 && bus3.cursor_col != 4'(c); i++) drive3(0, 0, 0, 1, 0, 0);
    check_eq("move_to3_row", bus3.cursor_row, r);
    check_eq("move_to3_col", bus3.cursor_col, c);
  endtask

  // Runs one scan; optionally pokes edit/move strobes mid-scan or asserts reset at a given cycle.
  task automatic scan3(input int poke_at, input int abort_at, output int cyc, output int rej);
    cyc = 0;
    rej = 0;
    bus3.validate_start = 1;
    do begin
      tick();
      bus3.validate_start = 0;
      bus3.write_en = 0; bus3.move_right = 0; bus3.user_value = 0;
      cyc++;
      rej += int'(bus3.edit_reject);
      if (cyc == abort_at) begin
        reset = 1;
        #1;
        break;
      end
      if (cyc == poke_at) begin
        bus3.write_en = 1; bus3.move_right = 1; bus3.user_value = 3;
      end
    end while (!bus3.valid_done && cyc < 400);
  endtask

  task automatic scan2(output int cyc);
    cyc = 0;
    bus2.validate_start = 1;
    do begin
      tick();
      bus2.validate_start = 0;
      cyc++;
    end while (!bus2.valid_done && cyc < 200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, done_cnt, cyc, rej, cyc_b;
    logic acc;

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        sol3[r][c]  = 4'(sol_val(3, r, c));
        expm3[r][c] = (((r * 9 + c) * 11) % 27) < 10;
        exp3[r][c]  = expm3[r][c] ? sol3[r][c] : 4'd0;
        puz3[r * 9 + c] = exp3[r][c];
      end
    puz3[1] = 4'd12;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sol2[r][c]  = 3'(sol_val(2, r, c));
        exp2[r][c]  = sol2[r][c];
        expm2[r][c] = 1'b1;
        puz2[r * 4 + c] = sol2[r][c];
      end
    puz2[5] = 3'd7;
    exp2[1][1] = 3'd0;
    expm2[1][1] = 1'b0;

    bus3.load_start = 0; bus3.load_valid = 0; bus3.load_value = 0; bus3.validate_start = 0;
    bus3.move_up = 0; bus3.move_down = 0; bus3.move_left = 0; bus3.move_right = 0;
    bus3.write_en = 0; bus3.user_value = 0;
    bus2.load_start = 0; bus2.load_valid = 0; bus2.load_value = 0; bus2.validate_start = 0;
    bus2.move_up = 0; bus2.move_down = 0; bus2.move_left = 0; bus2.move_right = 0;
    bus2.write_en = 0; bus2.user_value = 0;

    repeat (3) tick();
    reset = 0;
    check_eq("rst_busy", bus3.busy, 0);
    check_eq("rst_ok", bus3.board_ok, 0);
    check_eq("rst_full", bus3.board_full, 0);
    check_eq("rst_cursor", {bus3.cursor_row, bus3.cursor_col}, 0);
    check_eq("rst_grid", $countones(bus3.display_grid), 0);

    // Reset in the middle of a load stream
    bus3.load_start = 1;
    tick();
    bus3.load_start = 0;
    check_eq("load_ready_hi", bus3.load_ready, 1);
    bus3.load_valid = 1;
    for (int i = 0; i < 10; i++) begin
      bus3.load_value = puz3[i];
      tick();
    end
    check_eq("partial_grid_nz", bus3.display_grid[0][0], 1);
    reset = 1;
    #1;
    check_eq("midload_busy", bus3.busy, 0);
    check_eq("midload_ready", bus3.load_ready, 0);
    check_eq("midload_grid", $countones(bus3.display_grid), 0);
    check_eq("midload_mask", $countones(bus3.given_mask), 0);
    bus3.load_valid = 0;
    tick();
    reset = 0;

    // Full load with random valid gaps
    beat = 0; done_cnt = 0; cyc = 0;
    bus3.load_start = 1;
    tick();
    bus3.load_start = 0;
    while (beat < 81 && cyc < 2000) begin
      bus3.load_valid = ($urandom_range(0, 2) != 0);
      bus3.load_value = puz3[beat];
      acc = bus3.load_valid && bus3.load_ready;
      tick();
      cyc++;
      if (bus3.load_done) done_cnt++;
      if (acc) beat++;
    end
    bus3.load_valid = 0;
    repeat (3) begin
      tick();
      if (bus3.load_done) done_cnt++;
    end
    check_eq("load3_beats", beat, 81);
    check_eq("load3_done_once", done_cnt, 1);
    check_eq("load3_grid", grid3_mism(), 0);
    check_eq("load3_givens", $countones(bus3.given_mask), 30);
    check_eq("load3_cursor", {bus3.cursor_row, bus3.cursor_col}, 0);
    check_eq("load3_busy", bus3.busy, 0);

    // Cursor wrap and cancel
    drive3(1, 0, 0, 0, 0, 0);
    check_eq("wrap_up_row", bus3.cursor_row, 8);
    drive3(0, 0, 1, 0, 0, 0);
    check_eq("wrap_left_col", bus3.cursor_col, 8);
    drive3(1, 1, 0, 0, 0, 0);
    check_eq("updn_cancel", {bus3.cursor_row, bus3.cursor_col}, {4'd8, 4'd8});
    for (int i = 0; i < 9; i++) drive3(0, 0, 0, 1, 0, 0);
    check_eq("right9_col", bus3.cursor_col, 8);
    drive3(0, 1, 0, 0, 0, 0);
    check_eq("wrap_down_row", bus3.cursor_row, 0);
    drive3(0, 0, 0, 1, 0, 0);
    check_eq("wrap_right_col", bus3.cursor_col, 0);

    // Edits: given cell, out-of-range value, erase of empty cell, write+move
    drive3(0, 0, 0, 0, 1, 4'd5);
    check_eq("given_reject", bus3.edit_reject, 1);
    check_eq("given_unchanged", bus3.display_grid[0][0], 1);
    tick();
    check_eq("reject_pulse_end", bus3.edit_reject, 0);
    drive3(0, 0, 0, 1, 0, 0);
    drive3(0, 0, 0, 0, 1, 4'd10);
    check_eq("big_reject", bus3.edit_reject, 1);
    check_eq("big_unchanged", bus3.display_grid[0][1], 0);
    drive3(0, 0, 0, 0, 1, 4'd0);
    check_eq("erase_no_reject", bus3.edit_reject, 0);
    check_eq("erase_cell", bus3.display_grid[0][1], 0);
    drive3(0, 0, 0, 1, 1, 4'd2);
    check_eq("wr_move_cell", bus3.display_grid[0][1], 2);
    check_eq("wr_move_col", bus3.cursor_col, 2);
    exp3[0][1] = 4'd2;

    // Fill the whole solution row-major, writing while stepping the cursor
    move_to3(0, 0);
    rej = 0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        drive3(0, c == 8, 0, 1, 1, sol3[r][c]);
        rej += int'(bus3.edit_reject);
        exp3[r][c] = sol3[r][c];
      end
    check_eq("fill_rejects", rej, 30);
    check_eq("fill_grid", grid3_mism(), 0);
    check_eq("fill_cursor", {bus3.cursor_row, bus3.cursor_col}, 0);

    scan3(5, 0, cyc, rej);
    check_eq("scan3_cycles", cyc, 244);
    check_eq("scan3_ok", bus3.board_ok, 1);
    check_eq("scan3_full", bus3.board_full, 1);
    check_eq("scan3_edit_ignored", rej, 0);
    check_eq("scan3_cursor_held", {bus3.cursor_row, bus3.cursor_col}, 0);
    check_eq("scan3_grid_held", grid3_mism(), 0);
    tick();
    check_eq("scan3_done_pulse", bus3.valid_done, 0);
    check_eq("scan3_ok_hold", bus3.board_ok, 1);

    // Duplicate 5 inside box 4
    move_to3(3, 4);
    drive3(0, 0, 0, 0, 1, 4'd5);
    exp3[3][4] = 4'd5;
    scan3(0, 0, cyc, rej);
    check_eq("dup_ok", bus3.board_ok, 0);
    check_eq("dup_full", bus3.board_full, 1);

    // Consistent but incomplete board
    drive3(0, 0, 0, 0, 1, 4'd0);
    exp3[3][4] = 4'd0;
    scan3(0, 0, cyc, rej);
    check_eq("part_ok", bus3.board_ok, 1);
    check_eq("part_full", bus3.board_full, 0);

    // Reset in the middle of a scan
    scan3(0, 100, cyc_b, rej);
    check_eq("abort_cycle", cyc_b, 100);
    check_eq("abort_ok", bus3.board_ok, 0);
    check_eq("abort_full", bus3.board_full, 0);
    check_eq("abort_busy", bus3.busy, 0);
    check_eq("abort_grid", $countones(bus3.display_grid), 0);
    check_eq("abort_mask", $countones(bus3.given_mask), 0);
    tick();
    reset = 0;

    // 4x4 instance
    beat = 0; done_cnt = 0; cyc = 0;
    bus2.load_start = 1;
    tick();
    bus2.load_start = 0;
    while (beat < 16 && cyc < 200) begin
      bus2.load_valid = (cyc != 3);
      bus2.load_value = puz2[beat];
      acc = bus2.load_valid && bus2.load_ready;
      tick();
      cyc++;
      if (bus2.load_done) done_cnt++;
      if (acc) beat++;
    end
    bus2.load_valid = 0;
    tick();
    if (bus2.load_done) done_cnt++;
    check_eq("load2_done_once", done_cnt, 1);
    check_eq("load2_grid", grid2_mism(), 0);
    check_eq("load2_givens", $countones(bus2.given_mask), 15);

    scan2(cyc);
    check_eq("scan2_cycles", cyc, 49);
    check_eq("scan2_ok", bus2.board_ok, 1);
    check_eq("scan2_full", bus2.board_full, 0);

    drive2(0, 0, 1, 0, 0, 0);
    check_eq("wrap2_left", bus2.cursor_col, 3);
    drive2(1, 0, 0, 0, 0, 0);
    check_eq("wrap2_up", bus2.cursor_row, 3);
    drive2(0, 1, 0, 1, 0, 0);
    check_eq("wrap2_back", {bus2.cursor_row, bus2.cursor_col}, 0);
    drive2(0, 1, 0, 1, 0, 0);
    drive2(0, 0, 0, 0, 1, 3'd5);
    check_eq("big2_reject", bus2.edit_reject, 1);
    drive2(0, 0, 0, 0, 1, 3'd4);
    check_eq("wr2_no_reject", bus2.edit_reject, 0);
    check_eq("wr2_cell", bus2.display_grid[1][1], 4);

    scan2(cyc);
    check_eq("scan2b_cycles", cyc, 49);
    check_eq("scan2b_ok", bus2.board_ok, 1);
    check_eq("scan2b_full", bus2.board_full, 1);

    drive2(0, 0, 0, 0, 1, 3'd1);
    scan2(cyc);
    check_eq("dup2_ok", bus2.board_ok, 0);
    check_eq("dup2_full", bus2.board_full, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
